regfile_writeback: RTL and testbench

Write-back controller that owns the register file's write port (`we`, `wa`, `wd`). It accepts results from two producers, the ALU and the load unit, over independent valid/ready channels and arbitrates them round-robin. Accepted writes are queued in order in a small FIFO and retired one per cycle onto the register-file write port. While writes are pending, the block supplies bypass data for the two register-file read addresses so that operand fetch never sees a stale register.

---
 rtl/regfile_writeback.sv | 143 ++++++++++++++
 tb/tb_regfile_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback
//
// Owns the register-file write port. Two producers (ALU on channel A and the
// load unit on channel B) offer results over valid/ready handshakes. A
// round-robin arbiter accepts at most one result per cycle into an in-order
// write queue. The queue retires one entry per cycle onto we/wa/wd unless
// hold is asserted. While writes are pending, the block supplies bypass data
// for two read addresses so operand fetch never sees a stale register.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   ALU result channel
//   b_valid/b_ready/b_addr/b_data   load result channel
//   hold                       suppress retirement this cycle
//   we, wa, wd                 register-file write port (head of queue)
//   ra1, ra2                   read addresses being fetched
//   byp1_hit/byp1_data         youngest pending write matching ra1
//   byp2_hit/byp2_data         youngest pending write matching ra2
//   pending                    number of queued writes
module regfile_writeback #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_data,
    input  logic                       hold,
    output logic                       we,
    output logic [ADDR_W-1:0]          wa,
    output logic [DATA_W-1:0]          wd,
    input  logic [ADDR_W-1:0]          ra1,
    input  logic [ADDR_W-1:0]          ra2,
    output logic                       byp1_hit,
    output logic [DATA_W-1:0]          byp1_data,
    output logic                       byp2_hit,
    output logic [DATA_W-1:0]          byp2_data,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Queue storage carries no reset: only entries below count are ever used.
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              last_b;   // 1 when the most recent accept came from B

    logic              full;
    logic              empty;
    logic              grant_a;
    logic              grant_b;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // On a tie, the source that did not win last time gets the grant.
    assign grant_a = a_valid & (~b_valid | last_b);
    assign grant_b = b_valid & (~a_valid | ~last_b);

    // Ready depends only on registered occupancy, so a full queue refuses
    // even when it is popping this cycle.
    assign a_ready = ~full & grant_a;
    assign b_ready = ~full & grant_b;

    assign push      = a_ready | b_ready;
    assign push_addr = a_ready ? a_addr : b_addr;
    assign push_data = a_ready ? a_data : b_data;

    // Retire the head; the pop coincides with the register-file capture edge.
    assign pop     = ~empty & ~hold;
    assign we      = pop;
    assign wa      = pop ? q_addr[head] : '0;
    assign wd      = pop ? q_data[head] : '0;
    assign pending = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            last_b <= 1'b1;
        end else begin
            if (push) begin
                tail   <= tail + PTR_W'(1);
                last_b <= b_ready;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= push_addr;
            q_data[tail] <= push_data;
        end
    end

    // Walk valid entries from oldest to youngest; a later match overrides an
    // earlier one, leaving the youngest matching data. The head entry being
    // retired this cycle is still included.
    always_comb begin
        byp1_hit  = 1'b0;
        byp1_data = '0;
        byp2_hit  = 1'b0;
        byp2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (q_addr[head + PTR_W'(i)] == ra1) begin
                    byp1_hit  = 1'b1;
                    byp1_data = q_data[head + PTR_W'(i)];
                end
                if (q_addr[head + PTR_W'(i)] == ra2) begin
                    byp2_hit  = 1'b1;
                    byp2_data = q_data[head + PTR_W'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, a_ready, b_valid, b_ready, hold, we;
    logic [ADDR_W-1:0] a_addr, b_addr, wa, ra1, ra2;
    logic [DATA_W-1:0] a_data, b_data, wd, byp1_data, byp2_data;
    logic              byp1_hit, byp2_hit;
    logic [CNT_W-1:0]  pending;

    always #5 clk = ~clk;

    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .hold(hold), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .byp1_hit(byp1_hit), .byp1_data(byp1_data),
        .byp2_hit(byp2_hit), .byp2_data(byp2_data), .pending(pending)
    );

    // Reference model: the queue of pending writes in acceptance order.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t              mq[$];
    bit                m_last_b;
    int                tests;
    int                fails;
    int                winner;
    bit                e_ar, e_br, e_we, h1, h2;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd, d1, d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, mid-cycle.
    task automatic check();
        @(negedge clk);
        winner = 0;
        if (a_valid && b_valid) winner = m_last_b ? 1 : 2;
        else if (a_valid)       winner = 1;
        else if (b_valid)       winner = 2;
        if (mq.size() >= DEPTH) winner = 0;
        e_ar = (winner == 1);
        e_br = (winner == 2);
        e_we = (mq.size() > 0) && !hold;
        e_wa = e_we ? mq[0].addr : '0;
        e_wd = e_we ? mq[0].data : '0;
        h1 = 0; d1 = '0; h2 = 0; d2 = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].addr == ra1) begin h1 = 1; d1 = mq[i].data; end
            if (mq[i].addr == ra2) begin h2 = 1; d2 = mq[i].data; end
        end
        chk("a_ready",   32'(a_ready),   32'(e_ar));
        chk("b_ready",   32'(b_ready),   32'(e_br));
        chk("we",        32'(we),        32'(e_we));
        chk("wa",        32'(wa),        32'(e_wa));
        chk("wd",        32'(wd),        32'(e_wd));
        chk("pending",   32'(pending),   32'(mq.size()));
        chk("byp1_hit",  32'(byp1_hit),  32'(h1));
        chk("byp1_data", 32'(byp1_data), 32'(d1));
        chk("byp2_hit",  32'(byp2_hit),  32'(h2));
        chk("byp2_data", 32'(byp2_data), 32'(d2));
    endtask

    // Apply the edge to the model, then step just past it for new stimulus.
    task automatic advance();
        @(posedge clk);
        if (e_we) void'(mq.pop_front());
        if (e_ar) begin
            mq.push_back(ent_t'({a_addr, a_data}));
            m_last_b = 0;
        end else if (e_br) begin
            mq.push_back(ent_t'({b_addr, b_data}));
            m_last_b = 1;
        end
        #1;
    endtask

    task automatic step();
        check();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_valid = 0; b_valid = 0; hold = 0;
        mq.delete();
        m_last_b = 1;
        e_ar = 0; e_br = 0; e_we = 0;
        #2;
        chk("rst_we",        32'(we),        32'(0));
        chk("rst_wa",        32'(wa),        32'(0));
        chk("rst_wd",        32'(wd),        32'(0));
        chk("rst_pending",   32'(pending),   32'(0));
        chk("rst_byp1_hit",  32'(byp1_hit),  32'(0));
        chk("rst_byp2_hit",  32'(byp2_hit),  32'(0));
        chk("rst_byp1_data", 32'(byp1_data), 32'(0));
        chk("rst_a_ready",   32'(a_ready),   32'(0));
        chk("rst_b_ready",   32'(b_ready),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0; fails = 0;
        a_valid = 0; b_valid = 0; hold = 0;
        a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
        ra1 = '0; ra2 = '0;
        rst_n = 1'b0;
        #1;
        do_reset();

        // Single write: A writes r2 = 0x5A.
        a_valid = 1; a_addr = 2'd2; a_data = 8'h5A;
        check();
        chk("t1_accept", 32'(a_ready), 32'(1));
        advance();
        a_valid = 0;
        check();
        chk("t1_we", 32'(we), 32'(1));
        chk("t1_wa", 32'(wa), 32'(2));
        chk("t1_wd", 32'(wd), 32'(8'h5A));
        advance();
        check();
        chk("t1_idle_we",   32'(we),      32'(0));
        chk("t1_idle_pend", 32'(pending), 32'(0));
        advance();

        // Tie round-robin from reset: grants A, B, A, B.
        do_reset();
        a_valid = 1; a_addr = 2'd1; a_data = 8'h11;
        b_valid = 1; b_addr = 2'd3; b_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            check();
            chk("t2_grant_a",  32'(a_ready),      32'(i % 2 == 0));
            chk("t2_pend_le1", 32'(pending <= 1), 32'(1));
            advance();
        end
        a_valid = 0; b_valid = 0;
        repeat (3) step();

        // Full under hold: the fifth write is refused until count drops.
        hold = 1;
        for (int k = 0; k < 5; k++) begin
            a_valid = 1; a_addr = ADDR_W'(k % 4); a_data = DATA_W'(k + 1);
            check();
            if (k < 4) begin
                chk("t3_accept", 32'(a_ready), 32'(1));
            end else begin
                chk("t3_full_ready", 32'(a_ready), 32'(0));
                chk("t3_full_pend",  32'(pending), 32'(4));
                chk("t3_full_we",    32'(we),      32'(0));
            end
            advance();
        end
        hold = 0;
        check();
        chk("t3_pop_full_ready", 32'(a_ready), 32'(0));
        chk("t3_first_wa",       32'(wa),      32'(0));
        chk("t3_first_wd",       32'(wd),      32'(1));
        advance();
        check();
        chk("t3_fifth_accept", 32'(a_ready), 32'(1));
        advance();
        a_valid = 0;
        repeat (5) step();

        // Bypass returns the youngest matching entry.
        hold = 1;
        a_valid = 1; a_addr = 2'd2; a_data = 8'hAA;
        step();
        a_data = 8'hBB;
        step();
        a_valid = 0; ra1 = 2'd2; ra2 = 2'd1;
        check();
        chk("t4_byp1_hit",  32'(byp1_hit),  32'(1));
        chk("t4_byp1_data", 32'(byp1_data), 32'(8'hBB));
        chk("t4_byp2_hit",  32'(byp2_hit),  32'(0));
        chk("t4_byp2_data", 32'(byp2_data), 32'(0));
        advance();
        hold = 0;
        repeat (3) step();

        // Push and pop in the same cycle keep the count.
        hold = 1;
        a_valid = 1; a_addr = 2'd0; a_data = 8'h10;
        step();
        a_addr = 2'd1; a_data = 8'h20;
        step();
        a_valid = 0; hold = 0;
        b_valid = 1; b_addr = 2'd3; b_data = 8'h30;
        check();
        chk("t5_b_accept", 32'(b_ready), 32'(1));
        advance();
        b_valid = 0;
        check();
        chk("t5_pending", 32'(pending), 32'(2));
        advance();
        repeat (3) step();

        // Asynchronous reset with three writes queued.
        hold = 1;
        for (int k = 0; k < 3; k++) begin
            a_valid = 1; a_addr = ADDR_W'(k); a_data = DATA_W'(8'h61 + k);
            step();
        end
        a_valid = 0; hold = 0;
        #1;
        chk("t6_we_before", 32'(we), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_we_reset",   32'(we),      32'(0));
        chk("t6_pend_reset", 32'(pending), 32'(0));
        mq.delete();
        m_last_b = 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        a_valid = 1; a_addr = 2'd0; a_data = 8'h71;
        b_valid = 1; b_addr = 2'd1; b_data = 8'h72;
        check();
        chk("t6_tie_a", 32'(a_ready), 32'(1));
        chk("t6_tie_b", 32'(b_ready), 32'(0));
        advance();
        a_valid = 0; b_valid = 0;
        repeat (4) step();

        // Randomised traffic with producers obeying the hold-stable rule.
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || e_ar) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_addr  = ADDR_W'($urandom_range(0, 3));
                a_data  = DATA_W'($urandom_range(0, 255));
            end
            if (!b_valid || e_br) begin
                b_valid = ($urandom_range(0, 99) < 50);
                b_addr  = ADDR_W'($urandom_range(0, 3));
                b_data  = DATA_W'($urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 9) < 3);
            ra1  = ADDR_W'($urandom_range(0, 3));
            ra2  = ADDR_W'($urandom_range(0, 3));
            step();
        end
        a_valid = 0; b_valid = 0; hold = 0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
